alu_core: RTL and testbench

//  32-bit integer ALU for the RV32-style execute stage. Computes one of ten arithmetic/logic/shift ops

---
 rtl/alu_core_if.sv | 22 ++
 rtl/alu_core.sv | 98 +++++++++
 tb/tb_alu_core.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// alu_core_if: operand/opcode request and registered result/flags bundle for alu_core.
// Master drives the op, slave (the ALU) returns the result one cycle later.
interface alu_core_if;
    logic        in_valid;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  aluc;
    logic        out_valid;
    logic [31:0] out;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic        sign;
    modport master (
        output in_valid, src1, src2, aluc,
        input  out_valid, out, zero, cout, overflow, sign
    );
    modport slave (
        input  in_valid, src1, src2, aluc,
        output out_valid, out, zero, cout, overflow, sign
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: 32-bit RV32-style ALU, one-cycle registered result with zero/carry/overflow/sign flags.
// Define ALU_MUL_EN to add MUL (1010) and MULHU (1011); otherwise those opcodes return 0.
module alu_core (
    input logic      clk,
    input logic      rst,
    alu_core_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    logic [63:0] prod;
`endif
    logic        sub;
    logic [31:0] opb;
    logic [32:0] sum;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        res_c;
    logic        res_o;
    logic        valid_d, valid_q;
    logic [31:0] out_d, out_q;
    logic        zero_d, zero_q;
    logic        cout_d, cout_q;
    logic        ovf_d, ovf_q;
    logic        sign_d, sign_q;
    always_comb begin
        sub   = bus.aluc == OP_SUB;
        opb   = sub ? ~bus.src2 : bus.src2;
        sum   = {1'b0, bus.src1} + {1'b0, opb} + {32'd0, sub};
        shamt = bus.src2[4:0];
`ifdef ALU_MUL_EN
        prod  = {32'd0, bus.src1} * {32'd0, bus.src2};
`endif
        res   = '0;
        res_c = 1'b0;
        res_o = 1'b0;
        case (bus.aluc)
            OP_ADD, OP_SUB: begin
                res   = sum[31:0];
                res_c = sum[32];
                // SUB overflow reduces to the ADD rule once src2 is inverted
                res_o = (bus.src1[31] == opb[31]) && (sum[31] != bus.src1[31]);
            end
            OP_AND:  res = bus.src1 & bus.src2;
            OP_OR:   res = bus.src1 | bus.src2;
            OP_XOR:  res = bus.src1 ^ bus.src2;
            OP_SLT:  res = {31'd0, $signed(bus.src1) < $signed(bus.src2)};
            OP_SLTU: res = {31'd0, bus.src1 < bus.src2};
            OP_SLL:  res = bus.src1 << shamt;
            OP_SRL:  res = bus.src1 >> shamt;
            OP_SRA:  res = $signed(bus.src1) >>> shamt;
`ifdef ALU_MUL_EN
            OP_MUL:   res = prod[31:0];
            OP_MULHU: res = prod[63:32];
`endif
            default: res = '0;
        endcase
        valid_d = bus.in_valid;
        out_d   = bus.in_valid ? res : out_q;
        zero_d  = bus.in_valid ? (res == '0) : zero_q;
        cout_d  = bus.in_valid ? res_c : cout_q;
        ovf_d   = bus.in_valid ? res_o : ovf_q;
        sign_d  = bus.in_valid ? res[31] : sign_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            sign_q  <= sign_d;
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.sign      = sign_q;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vector table, hand-written pipeline/reset sequences and random ops
// checked against an arithmetic reference model of the ALU.
module tb_alu_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    alu_core_if bus ();
    alu_core dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct packed {
        logic [31:0] y;
        logic        z, c, o, s;
    } res_t;
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, y;
        logic        z, c, o, s;
    } vec_t;
    int vectors = 0;
    int miscompares = 0;
    logic        exp_valid = 1'b0;
    res_t        exp_res = '0;
    vec_t        vq[$];
    function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint sa, sb, sr;
        logic [63:0] p;
        int sh;
        r  = '0;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        sh = int'(b % 32);
        case (op)
            4'd0: begin
                p = {32'd0, a} + {32'd0, b};
                r.y = p[31:0];
                r.c = p[32];
                sr = sa + sb;
                r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                r.y = a - b;
                r.c = a >= b;
                sr = sa - sb;
                r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: r.y = a & b;
            4'd3: r.y = a | b;
            4'd4: r.y = a ^ b;
            4'd5: r.y = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: r.y = (a < b) ? 32'd1 : 32'd0;
            4'd7: r.y = 32'(64'(a) * (64'd1 << sh));
            4'd8: r.y = 32'(64'(a) / (64'd1 << sh));
            4'd9: r.y = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
`ifdef ALU_MUL_EN
            4'd10: begin p = {32'd0, a} * {32'd0, b}; r.y = p[31:0]; end
            4'd11: begin p = {32'd0, a} * {32'd0, b}; r.y = p[63:32]; end
`endif
            default: r.y = 32'd0;
        endcase
        r.z = r.y == 32'd0;
        r.s = r.y[31];
        return r;
    endfunction
    task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got valid/out/z/c/o/s=%h required %h", name, act, req);
        end
    endtask
    function automatic logic [36:0] dut_state();
        return {bus.out_valid, bus.out, bus.zero, bus.cout, bus.overflow, bus.sign};
    endfunction
    task automatic apply(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.aluc = op;
        bus.src1 = a;
        bus.src2 = b;
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0;
            exp_res = '0;
        end else begin
            exp_valid = v;
            if (v) exp_res = model(op, a, b);
        end
        #1;
        check("model", dut_state(), {exp_valid, exp_res});
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.aluc = 4'd0;
        bus.src1 = '0;
        bus.src2 = '0;
        vq.push_back('{4'd0, 32'd15, 32'd10, 32'd25, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd1, 32'd20, 32'd10, 32'd10, 1'b0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1});
        vq.push_back('{4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        vq.push_back('{4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        vq.push_back('{4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0});
        vq.push_back('{4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd3, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1'b0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'd4, 32'hFFFF_0000, 32'h00FF_FF00, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'd5, 32'hFFFF_FFFB, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd6, 32'd5, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd6, 32'hFFFF_FFFB, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd5, 32'd2, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd7, 32'd1, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd8, 32'h8000_0000, 32'd2, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd9, 32'hFFFF_FFFC, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'd7, 32'd1, 32'd35, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd9, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'd12, 32'h1234_5678, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef ALU_MUL_EN
        vq.push_back('{4'd10, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd11, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0});
`else
        vq.push_back('{4'd10, 32'd6, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'd11, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
`endif
        // reset state, with a valid op presented while reset is held
        apply(1'b1, 4'd0, 32'd1, 32'd2);
        check("reset_hold", dut_state(), 37'd0);
        #2 rst = 1'b0;
        foreach (vq[i]) begin
            apply(1'b1, vq[i].op, vq[i].a, vq[i].b);
            check($sformatf("vec%0d_op%0d", i, vq[i].op), dut_state(),
                  {1'b1, vq[i].y, vq[i].z, vq[i].c, vq[i].o, vq[i].s});
        end
        // back-to-back stream then idle: results in order, last result held
        apply(1'b1, 4'd0, 32'd100, 32'd1);
        apply(1'b1, 4'd1, 32'd100, 32'd1);
        apply(1'b1, 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        apply(1'b1, 4'd7, 32'd3, 32'd4);
        check("pipe_last", dut_state(), {1'b1, 32'd48, 4'b0000});
        apply(1'b0, 4'd0, 32'hDEAD_BEEF, 32'd1);
        check("pipe_hold1", dut_state(), {1'b0, 32'd48, 4'b0000});
        apply(1'b0, 4'd1, 32'd0, 32'd0);
        check("pipe_hold2", dut_state(), {1'b0, 32'd48, 4'b0000});
        // asynchronous reset mid-cycle clears everything without a clock edge
        apply(1'b1, 4'd1, 32'd0, 32'd1);
        #2 rst = 1'b1;
        #1 check("async_rst", dut_state(), 37'd0);
        exp_valid = 1'b0;
        exp_res = '0;
        apply(1'b1, 4'd0, 32'd5, 32'd6);
        #2 rst = 1'b0;
        apply(1'b0, 4'd0, 32'd5, 32'd6);
        check("rst_release_idle", dut_state(), 37'd0);
        apply(1'b1, 4'd0, 32'd5, 32'd6);
        check("first_after_rst", dut_state(), {1'b1, 32'd11, 4'b0000});
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, {31{a[0]}}};
            if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) b = a;
            apply($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
